io_unit: RTL and testbench
==========================

IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter OUT_DEPTH, default 4, output FIFO depth in words (power of two, 2..16).
REQ-002 Parameter IN_TIMEOUT, default 255, max cycles WAIT_IN waits for external data (1..65535).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 cpu_out_req  in  1  one-cycle pulse from CPU OUT execute state; push cpu_out_data.
REQ-006 cpu_out_data  in  16  word to transmit (CPU register_A).
REQ-007 cpu_out_full  out  1  high when FIFO count == OUT_DEPTH.
REQ-008 cpu_in_req  in  1  one-cycle pulse from CPU IN execute state; request one input word.
REQ-009 cpu_in_data  out  16  returned input word; held until next completed IN.
REQ-010 cpu_in_done  out  1  one-cycle pulse, cpu_in_data valid.
REQ-011 cpu_busy  out  1  CPU stays in its wait state while high.
REQ-012 ext_out_data  out  16  FIFO head word.
REQ-013 ext_out_valid  out  1  FIFO non-empty.
REQ-014 ext_out_ready  in  1  external sink accepts head when valid&ready.
REQ-015 ext_in_data  in  16  external input word.
REQ-016 ext_in_valid  in  1  external word present.
REQ-017 ext_in_ready  out  1  high only in WAIT_IN; transfer on valid&ready.
REQ-018 status  out  2  sticky flags {in_timeout, out_overflow}.

Function
REQ-019 Output FIFO: circular buffer, read/write pointers wrap modulo OUT_DEPTH, count 0..OUT_DEPTH.
REQ-020 Push when cpu_out_req and (count<OUT_DEPTH or pop same cycle); written word visible on ext_out_data/ext_out_valid next cycle (latency 1).
REQ-021 Pop when ext_out_valid & ext_out_ready; head advances next cycle.
REQ-022 Push+pop same cycle: count unchanged, both pointers advance; legal when full.
REQ-023 cpu_out_req when full with no pop: word dropped, count unchanged, status[0] set.
REQ-024 ext_out_data order strictly FIFO; no word duplicated or lost except REQ-023 case.
REQ-025 Input FSM states IDLE, WAIT_IN, DONE.
REQ-026 IDLE: cpu_in_req -> WAIT_IN, timeout counter cleared to 0.
REQ-027 WAIT_IN: ext_in_valid -> capture ext_in_data into cpu_in_data, -> DONE.
REQ-028 WAIT_IN, no valid: counter +1; when counter reaches IN_TIMEOUT-1 with no valid -> cpu_in_data=16'hFFFF, status[1] set, -> DONE.
REQ-029 Valid on the timeout cycle wins: data captured, no timeout flag.
REQ-030 DONE: cpu_in_done=1 for exactly one cycle, -> IDLE.
REQ-031 cpu_in_req outside IDLE ignored, not queued.
REQ-032 cpu_busy = (state != IDLE) or (cpu_in_req in IDLE), combinational; busy through DONE.
REQ-033 cpu_busy independent of FIFO state; out path never stalls CPU.
REQ-034 status bits clear only on reset.
REQ-035 In and out paths fully independent; simultaneous cpu_in_req and cpu_out_req both serviced.

Reset
REQ-036 reset high at clock edge: FSM=IDLE, pointers/count/timeout counter=0, cpu_in_data=0, status=0.
REQ-037 Outputs after reset: cpu_out_full=0, cpu_in_done=0, cpu_busy=0, ext_out_valid=0, ext_in_ready=0, ext_out_data=don't-care.
REQ-038 Reset mid-WAIT_IN or with FIFO non-empty: transaction and queued words discarded, no cpu_in_done pulse.
REQ-039 Reset overrides all simultaneous requests in same cycle.

Verification
REQ-040 ext_out_ready=0; push 16'h0001..16'h0004 -> cpu_out_full=1 after 4th; push 16'h0005 -> dropped, status=2'b01; ready=1 -> 0001..0004 emitted in order.
REQ-041 Full FIFO, ready=1, push 16'hBEEF same cycle -> accepted, count stays 4, BEEF emitted 5th.
REQ-042 cpu_in_req, ext_in_valid=1 with 16'h1234 two cycles later -> cpu_in_data=16'h1234, cpu_in_done single pulse, cpu_busy low next cycle.
REQ-043 IN_TIMEOUT=8, cpu_in_req, no valid -> after 8 WAIT_IN cycles cpu_in_data=16'hFFFF, status[1]=1.
REQ-044 Reset asserted in WAIT_IN with 3 words queued -> next cycle ext_out_valid=0, cpu_busy=0, status=0, no done pulse.
REQ-045 Second cpu_in_req during WAIT_IN -> ignored; exactly one cpu_in_done pulse.

Source files
------------

// File: rtl/io_unit_if.sv
// CPU-side and external-side handshake signals of the I/O unit.
// The slave modport is the io_unit view; master is the CPU/peripheral view.
interface io_unit_if;
  logic        cpu_out_req;
  logic [15:0] cpu_out_data;
  logic        cpu_out_full;
  logic        cpu_in_req;
  logic [15:0] cpu_in_data;
  logic        cpu_in_done;
  logic        cpu_busy;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [1:0]  status;

  modport slave (
    input  cpu_out_req, cpu_out_data, cpu_in_req, ext_out_ready, ext_in_data, ext_in_valid,
    output cpu_out_full, cpu_in_data, cpu_in_done, cpu_busy, ext_out_data, ext_out_valid,
           ext_in_ready, status
  );

  modport master (
    output cpu_out_req, cpu_out_data, cpu_in_req, ext_out_ready, ext_in_data, ext_in_valid,
    input  cpu_out_full, cpu_in_data, cpu_in_done, cpu_busy, ext_out_data, ext_out_valid,
           ext_in_ready, status
  );
endinterface

// File: rtl/io_unit.sv
// CPU I/O unit: buffered output FIFO toward an external sink and a blocking,
// timeout-guarded single-word input path. Both paths operate independently.
module io_unit #(
  parameter int unsigned OUT_DEPTH  = 4,
  parameter int unsigned IN_TIMEOUT = 255
) (
  input logic       clock,
  input logic       reset,
  io_unit_if.slave  bus
);

  localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

  // ---------------- output FIFO ----------------
  logic [15:0]   mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, overflow;
  logic          out_overflow;

  assign full  = (count == CW'(OUT_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && bus.ext_out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the word.
  assign push     = bus.cpu_out_req && (!full || pop);
  assign overflow = bus.cpu_out_req && full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.cpu_out_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (overflow) out_overflow <= 1'b1;
    end
  end

  assign bus.ext_out_data  = mem[rd_ptr];
  assign bus.ext_out_valid = !empty;
  assign bus.cpu_out_full  = full;

  // ---------------- input FSM ----------------
  typedef enum logic [1:0] {IDLE, WAIT_IN, DONE} in_state_t;

  in_state_t   state, state_nxt;
  logic [15:0] timer;
  logic [15:0] in_data;
  logic        in_timeout;
  logic        capture, timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (bus.cpu_in_req) state_nxt = WAIT_IN;
      WAIT_IN: begin
        // Valid data on the final cycle takes priority over the timeout.
        if (bus.ext_in_valid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (timer == 16'(IN_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer      <= '0;
      in_data    <= '0;
      in_timeout <= 1'b0;
    end else begin
      if (state == IDLE)        timer <= '0;
      else if (state == WAIT_IN) timer <= timer + 16'd1;
      if (capture)     in_data <= bus.ext_in_data;
      if (timeout_hit) begin
        in_data    <= '1;
        in_timeout <= 1'b1;
      end
    end
  end

  assign bus.cpu_in_data  = in_data;
  assign bus.cpu_in_done  = (state == DONE);
  assign bus.ext_in_ready = (state == WAIT_IN);
  assign bus.cpu_busy     = (state != IDLE) || bus.cpu_in_req;
  assign bus.status       = {in_timeout, out_overflow};

endmodule

// File: tb/tb_io_unit.sv
// Directed bench for io_unit: FIFO ordering/overflow, input capture,
// timeout boundary, reset discard and request-ignore behaviour.
module tb_io_unit;
  logic clock = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  io_unit_if bus ();

  io_unit #(.OUT_DEPTH(4), .IN_TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.cpu_out_req  = 1'b1;
    bus.cpu_out_data = w;
    tick();
    bus.cpu_out_req  = 1'b0;
  endtask

  initial begin
    int unsigned n;
    int unsigned dones;
    reset = 1'b1;
    bus.cpu_out_req = 0; bus.cpu_out_data = '0; bus.cpu_in_req = 0;
    bus.ext_out_ready = 0; bus.ext_in_data = '0; bus.ext_in_valid = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_full",   32'(bus.cpu_out_full),  0);
    check("rst_done",   32'(bus.cpu_in_done),   0);
    check("rst_busy",   32'(bus.cpu_busy),      0);
    check("rst_ovalid", 32'(bus.ext_out_valid), 0);
    check("rst_iready", 32'(bus.ext_in_ready),  0);
    check("rst_status", 32'(bus.status),        0);
    check("rst_indata", 32'(bus.cpu_in_data),   0);

    // Fill, overflow, drain in order
    push_word(16'h0001);
    check("lat1_valid", 32'(bus.ext_out_valid), 1);
    check("lat1_data",  32'(bus.ext_out_data),  32'h0001);
    for (int i = 2; i <= 4; i++) push_word(16'(i));
    check("full4", 32'(bus.cpu_out_full), 1);
    push_word(16'h0005);
    check("ovf_status", 32'(bus.status), 32'b01);
    check("ovf_full",   32'(bus.cpu_out_full), 1);
    bus.ext_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_data", 32'(bus.ext_out_data), 32'(i));
      tick();
    end
    check("drain_empty", 32'(bus.ext_out_valid), 0);
    bus.ext_out_ready = 1'b0;

    // Push+pop on a full FIFO
    push_word(16'h0011); push_word(16'h0022); push_word(16'h0033); push_word(16'h0044);
    bus.ext_out_ready = 1'b1;
    #1;
    check("pp_head", 32'(bus.ext_out_data), 32'h0011);
    push_word(16'hBEEF);
    check("pp_full", 32'(bus.cpu_out_full), 1);
    check("pp_status", 32'(bus.status), 32'b01);
    begin
      logic [15:0] exp_seq [4];
      exp_seq[0] = 16'h0022; exp_seq[1] = 16'h0033; exp_seq[2] = 16'h0044; exp_seq[3] = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
        check("pp_order", 32'(bus.ext_out_data), 32'(exp_seq[i]));
        tick();
      end
    end
    check("pp_empty", 32'(bus.ext_out_valid), 0);
    bus.ext_out_ready = 1'b0;

    // Input capture, with a simultaneous out push
    bus.cpu_in_req = 1'b1; bus.cpu_out_req = 1'b1; bus.cpu_out_data = 16'h7777;
    #1;
    check("in_busy_comb", 32'(bus.cpu_busy), 1);
    tick();
    bus.cpu_in_req = 1'b0; bus.cpu_out_req = 1'b0;
    check("sim_out_data", 32'(bus.ext_out_data), 32'h7777);
    check("sim_in_ready", 32'(bus.ext_in_ready), 1);
    tick();
    bus.ext_in_valid = 1'b1; bus.ext_in_data = 16'h1234;
    tick();
    bus.ext_in_valid = 1'b0;
    check("in_done",  32'(bus.cpu_in_done), 1);
    check("in_data",  32'(bus.cpu_in_data), 32'h1234);
    tick();
    check("in_done_pulse", 32'(bus.cpu_in_done), 0);
    check("in_busy_low",   32'(bus.cpu_busy),    0);
    check("in_data_hold",  32'(bus.cpu_in_data), 32'h1234);
    bus.ext_out_ready = 1'b1; tick(); bus.ext_out_ready = 1'b0;

    // Second request during WAIT_IN is ignored
    bus.cpu_in_req = 1'b1; tick();
    bus.cpu_in_req = 1'b1; tick();
    bus.cpu_in_req = 1'b0;
    bus.ext_in_valid = 1'b1; bus.ext_in_data = 16'h5678;
    tick();
    bus.ext_in_valid = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.cpu_in_done) dones++;
      tick();
    end
    check("dup_done_count", dones, 1);
    check("dup_busy",       32'(bus.cpu_busy), 0);
    check("dup_data",       32'(bus.cpu_in_data), 32'h5678);

    // Valid on the final timeout cycle wins
    bus.cpu_in_req = 1'b1; tick(); bus.cpu_in_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("edge_still_wait", 32'(bus.ext_in_ready), 1);
    bus.ext_in_valid = 1'b1; bus.ext_in_data = 16'hA5A5;
    tick();
    bus.ext_in_valid = 1'b0;
    check("edge_data",   32'(bus.cpu_in_data), 32'hA5A5);
    check("edge_status", 32'(bus.status), 32'b01);
    tick();

    // Timeout after 8 WAIT_IN cycles
    bus.cpu_in_req = 1'b1; tick(); bus.cpu_in_req = 1'b0;
    n = 0;
    while (bus.ext_in_ready && n < 20) begin
      n++;
      tick();
    end
    check("to_cycles", n, 8);
    check("to_done",   32'(bus.cpu_in_done), 1);
    check("to_data",   32'(bus.cpu_in_data), 32'hFFFF);
    check("to_status", 32'(bus.status), 32'b11);
    tick();

    // Reset mid-WAIT_IN with 3 queued words, requests raised during reset
    push_word(16'h0101); push_word(16'h0202); push_word(16'h0303);
    bus.cpu_in_req = 1'b1; tick(); bus.cpu_in_req = 1'b0;
    check("pre_rst_wait", 32'(bus.ext_in_ready), 1);
    reset = 1'b1; bus.cpu_in_req = 1'b1; bus.cpu_out_req = 1'b1; bus.cpu_out_data = 16'h0404;
    tick();
    reset = 1'b0; bus.cpu_in_req = 1'b0; bus.cpu_out_req = 1'b0;
    #1;
    check("mr_valid",  32'(bus.ext_out_valid), 0);
    check("mr_busy",   32'(bus.cpu_busy),      0);
    check("mr_status", 32'(bus.status),        0);
    check("mr_indata", 32'(bus.cpu_in_data),   0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cpu_in_done) dones++;
      tick();
    end
    check("mr_no_done", dones, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
